// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: RV32M multiply/divide for the execute stage, one radix-2 step per cycle.
// Optional macro MULDIV_FAST_MUL_EN: multiplies finish with a single-cycle product.
module ex_muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        flush,
   input  logic [2:0]  funct3,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [4:0]  rd_in,
   output logic        stall_req,
   output logic        result_valid,
   output logic [31:0] result,
   output logic [4:0]  rd_out,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] opb_q, opb_d;
   logic [2:0]  f3_q, f3_d;
   logic        neg_q, neg_d;
   logic [4:0]  rd_q, rd_d;
   logic        result_valid_q, result_valid_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  rd_out_q, rd_out_d;

   logic        is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, start_neg;
   logic [31:0] a_mag, b_mag, special_res;
   logic [32:0] mul_sum, div_diff;
   logic [63:0] mul_next, div_next, step, mul_fix;
   logic [31:0] div_field, div_fix, fin_res;

   assign is_div    = funct3[2];
   assign a_signed  = is_div ? ~funct3[0] : (funct3[1] ^ funct3[0]);
   assign b_signed  = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
   assign a_neg     = a_signed & op_a[31];
   assign b_neg     = b_signed & op_b[31];
   assign a_mag     = a_neg ? (32'd0 - op_a) : op_a;
   assign b_mag     = b_neg ? (32'd0 - op_b) : op_b;
   // Remainders take the dividend sign; everything else the product/quotient sign.
   assign start_neg = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
   assign div_zero  = is_div && (op_b == 32'd0);
   assign div_ovf   = is_div && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
   assign special_res = div_zero ? (funct3[1] ? op_a : 32'hFFFF_FFFF)
                                 : (funct3[1] ? 32'd0 : 32'h8000_0000);

   // prod_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
   assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opb_q} : 33'd0);
   assign mul_next = {mul_sum, prod_q[31:1]};
   assign div_diff = prod_q[63:31] - {1'b0, opb_q};
   assign div_next = div_diff[32] ? {prod_q[62:0], 1'b0} : {div_diff[31:0], prod_q[30:0], 1'b1};
   assign step     = f3_q[2] ? div_next : mul_next;

   assign mul_fix   = neg_q ? (64'd0 - step) : step;
   assign div_field = f3_q[1] ? step[63:32] : step[31:0];
   assign div_fix   = neg_q ? (32'd0 - div_field) : div_field;
   assign fin_res   = f3_q[2] ? div_fix : ((f3_q[1:0] == 2'b00) ? mul_fix[31:0] : mul_fix[63:32]);

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] fast_prod;
   assign fast_prod = {{32{a_neg}}, op_a} * {{32{b_neg}}, op_b};
`endif

   assign stall_req    = (state_q == IDLE && start && !flush) || (state_q == CALC);
   assign result_valid = result_valid_q;
   assign result       = result_q;
   assign rd_out       = rd_out_q;
   assign dbg_state    = state_q;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      prod_d         = prod_q;
      opb_d          = opb_q;
      f3_d           = f3_q;
      neg_d          = neg_q;
      rd_d           = rd_q;
      result_valid_d = 1'b0;
      result_d       = result_q;
      rd_out_d       = rd_out_q;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               f3_d   = funct3;
               rd_d   = rd_in;
               neg_d  = start_neg;
               opb_d  = b_mag;
               prod_d = {32'd0, a_mag};
               cnt_d  = 5'd0;
               if (div_zero || div_ovf) begin
                  state_d        = DONE;
                  result_valid_d = 1'b1;
                  result_d       = special_res;
                  rd_out_d       = rd_in;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!is_div) begin
                  state_d        = DONE;
                  result_valid_d = 1'b1;
                  result_d       = (funct3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
                  rd_out_d       = rd_in;
               end
`endif
               else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            prod_d = step;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d        = DONE;
               result_valid_d = 1'b1;
               result_d       = fin_res;
               rd_out_d       = rd_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Abort wins over everything, including the final CALC step.
      if (flush) begin
         state_d        = IDLE;
         cnt_d          = 5'd0;
         result_valid_d = 1'b0;
         result_d       = result_q;
         rd_out_d       = rd_out_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= 5'd0;
         prod_q         <= 64'd0;
         opb_q          <= 32'd0;
         f3_q           <= 3'd0;
         neg_q          <= 1'b0;
         rd_q           <= 5'd0;
         result_valid_q <= 1'b0;
         result_q       <= 32'd0;
         rd_out_q       <= 5'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         prod_q         <= prod_d;
         opb_q          <= opb_d;
         f3_q           <= f3_d;
         neg_q          <= neg_d;
         rd_q           <= rd_d;
         result_valid_q <= result_valid_d;
         result_q       <= result_d;
         rd_out_q       <= rd_out_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for ex_muldiv_unit against an arithmetic RV32M model.
// Latency expectations follow MULDIV_FAST_MUL_EN when it is defined for the build.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  funct3;
   logic [31:0] op_a, op_b;
   logic [4:0]  rd_in;
   logic        stall_req, result_valid;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   // {due cycle[31:0], rd[4:0], result[31:0]}
   logic [68:0] exp_q[$];
   logic [68:0] exp_e;

   ex_muldiv_unit dut (
      .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall_req(stall_req),
      .result_valid(result_valid), .result(result), .rd_out(rd_out), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish before 1ms");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      int          ia, ib;
      logic        ovf;
      sa  = $signed(a);
      sb  = $signed(b);
      ub  = {32'd0, b};
      ia  = $signed(a);
      ib  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!f[2]) return 1;
`endif
      return 33;
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- driver ----------------
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit in_done);
      int n, lat, sc, k;
      logic [31:0] due;
      if (!in_done) @(negedge clk);
      start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
      if (in_done) begin
         #1 chk("stall_start_in_done", {31'd0, stall_req}, 32'd0);
         @(negedge clk);
      end
      n   = cyc;
      lat = lat_of(f, a, b);
      due = n + lat;
      exp_q.push_back({due, rd, exp});
      #1 chk("stall_cycle_n", {31'd0, stall_req}, 32'd1);
      @(negedge clk);
      start = 1'b0; funct3 = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
      rd_in = 5'($urandom_range(0, 31));
      sc = 0;
      k  = 0;
      while (!result_valid && k < 40) begin
         if (stall_req) sc++;
         @(negedge clk);
         k++;
      end
      chk("valid_seen", {31'd0, result_valid}, 32'd1);
      chk("stall_in_done", {31'd0, stall_req}, 32'd0);
      chk("stall_cycles", sc, lat - 1);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!reset && result_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got result %h rd %0d expected no result", result, rd_out);
         end else begin
            exp_e = exp_q.pop_front();
            chk("result", result, exp_e[31:0]);
            chk("rd_out", {27'd0, rd_out}, {27'd0, exp_e[36:32]});
            chk("valid_cycle", cyc, exp_e[68:37]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int vc;
      logic [2:0]  f;
      logic [31:0] a, b;
      reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
      op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", {31'd0, result_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      reset = 1'b0;

      // directed cases with hand-computed answers
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 0);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0);
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 0);
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 0);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0);
      do_op(3'd5, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 0);
      do_op(3'd6, 32'd5, 32'd0, 5'd8, 32'd5, 0);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 0);
      do_op(3'd7, 32'd7, 32'd3, 5'd12, 32'd1, 0);
      do_op(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd13, 32'hFFFF_FFFF, 1);

      // flush takes priority over start in IDLE
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd2; rd_in = 5'd14;
      #1 chk("stall_flush_start", {31'd0, stall_req}, 32'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;

      // flush in cycle N+10 of a DIVU
      @(negedge clk);
      start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; rd_in = 5'd15;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("stall_after_flush", {31'd0, stall_req}, 32'd0);
      chk("state_after_flush", {30'd0, dbg_state}, 32'd0);
      vc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (result_valid) vc++;
      end
      chk("no_valid_after_flush", vc, 0);

      // reset between edges in the middle of CALC
      @(negedge clk);
      start = 1'b1; funct3 = 3'd4; op_a = $urandom; op_b = 32'd7; rd_in = 5'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, result_valid}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_rd_out", {27'd0, rd_out}, 32'd0);
      chk("midrst_stall", {31'd0, stall_req}, 32'd0);
      @(negedge clk);
      chk("midrst_hold_state", {30'd0, dbg_state}, 32'd0);
      reset = 1'b0;
      do_op(3'd7, 32'd100, 32'd7, 5'd21, 32'd2, 0);

      // randomized traffic against the model
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = rand_op();
         b = rand_op();
         do_op(f, a, b, 5'($urandom_range(0, 31)), model(f, a, b), 0);
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL have port: start  input  1  M-extension op present in execute; sampled only in IDLE.
REQ-004 SHALL have port: flush  input  1  synchronous abort of the instruction in execute (branch mispredict).
REQ-005 SHALL have port: funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: op_a  input  32  forwarded rs1 operand from execute.
REQ-007 SHALL have port: op_b  input  32  forwarded rs2 operand from execute.
REQ-008 SHALL have port: rd_in  input  5  destination register index from the ID/EX register.
REQ-009 SHALL have port: stall_req  output  1  combinational; holds PC, IF/ID and ID/EX while the op is in progress.
REQ-010 SHALL have port: result_valid  output  1  registered; result and rd_out valid this cycle.
REQ-011 SHALL have port: result  output  32  RV32M result.
REQ-012 SHALL have port: rd_out  output  5  destination index latched at start.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 SHALL define cycle N as a cycle with state IDLE, start=1, flush=0; op_a, op_b, funct3 and rd_in SHALL be latched at the end of cycle N.
REQ-015 SHALL transition IDLE->CALC at the end of cycle N with a 5-bit iteration counter cleared to 0.
REQ-016 SHALL perform one radix-2 step per cycle in CALC (shift-add multiply on sign-corrected magnitudes; restoring divide on magnitudes), for 32 cycles, N+1..N+32.
REQ-017 SHALL transition CALC->DONE when the counter reaches 31 (wraps to 0), so DONE occurs in cycle N+33.
REQ-018 SHALL hold result_valid=1 for exactly one cycle (DONE), then return to IDLE.
REQ-019 SHALL drive stall_req = (IDLE & start & !flush) | CALC; stall_req SHALL be 0 in DONE so the pipeline advances and consumes the result.
REQ-020 SHALL produce MUL = low 32 bits of the product; MULH/MULHSU/MULHU = high 32 bits of the signed*signed, signed*unsigned and unsigned*unsigned 64-bit product respectively.
REQ-021 SHALL produce DIV/REM truncating toward zero, with the remainder sign equal to the dividend sign.
REQ-022 SHALL handle divide-by-zero as follows: quotient 0xFFFFFFFF, remainder = op_a; CALC is skipped (IDLE->DONE, result_valid in N+1).
REQ-023 SHALL handle signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM) as follows: quotient 0x80000000, remainder 0; CALC is skipped.
REQ-024 SHALL return to IDLE on flush=1 in any state at the next edge, with result_valid=0; flush takes priority over start.
REQ-025 SHALL ignore start outside IDLE; a start in DONE is not accepted until the following IDLE cycle.
REQ-026 SHALL hold result and rd_out at their last values outside DONE.

Reset
REQ-027 SHALL, on reset=1, force state=IDLE, counter=0, result_valid=0, result=0, rd_out=0 and all internal accumulators to 0, and hold them while reset is high.
REQ-028 SHALL, on reset mid-CALC, discard the operation; stall_req SHALL be 0 while reset is high (with start=0).

Configuration
REQ-029 SHALL support macro MULDIV_FAST_MUL_EN.
REQ-030 SHALL, when MULDIV_FAST_MUL_EN is defined, compute multiply ops (funct3[2]=0) with a single-cycle 64-bit product: IDLE->DONE, result_valid in N+1, stall_req high only in cycle N; divide timing unchanged.
REQ-031 SHALL, when MULDIV_FAST_MUL_EN is undefined, use the iterative 32-cycle path for all ops per REQ-016..REQ-017.

Verification
REQ-032 SHALL pass: MUL op_a=7, op_b=0xFFFFFFFD -> result_valid in N+33 (N+1 with MULDIV_FAST_MUL_EN), result=0xFFFFFFEB, stall_req high N..N+32.
REQ-033 SHALL pass: MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> result=0x00000000.
REQ-034 SHALL pass: DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> result=0xFFFFFFFD; REM same operands -> result=0xFFFFFFFF.
REQ-035 SHALL pass: DIVU op_a=5, op_b=0 -> result=0xFFFFFFFF in N+1; REM op_a=5, op_b=0 -> result=5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in N+1.
REQ-036 SHALL pass: flush asserted in cycle N+10 of a DIVU -> IDLE at N+11, stall_req=0 from N+11, no result_valid pulse.
REQ-037 SHALL pass: reset asserted mid-CALC between clock edges -> result_valid, result, rd_out =0 immediately; a new start after release completes normally with the correct rd_out.
